// File: rtl/serial_rx_deserializer.sv
// Receive side of the LSB-first serial word link: synchronizes the remote bit clock and data,
// shifts one bit per falling edge and hands finished words over with a valid/ack handshake.
module serial_rx_deserializer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             SCLK_IN,
  input  logic             SIN,
  input  logic             RX_START,
  input  logic             RX_ACK,
  output logic [WIDTH-1:0] DOUT,
  output logic             RX_VALID,
  output logic             RX_DONE,
  output logic             RX_BUSY,
  output logic             RX_ERR,
  output logic             OVERRUN
);

  localparam int unsigned BitCntW = $clog2(WIDTH + 1);
  localparam int unsigned ToCntW  = $clog2(TIMEOUT + 1);

  localparam logic [BitCntW-1:0] BitLast = BitCntW'(WIDTH);
  localparam logic [ToCntW-1:0]  ToLast  = ToCntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRecv, StDone} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sin_sync_q;
  logic                   sclk_s, sin_s;
  logic                   sclk_d_q, sin_d_q;
  logic                   bit_edge;

  logic [BitCntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [ToCntW-1:0]  to_cnt_q, to_cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               rx_valid_q, rx_valid_d;
  logic               rx_err_q, rx_err_d;
  logic               overrun_q, overrun_d;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign sin_s  = sin_sync_q[SYNC_STAGES-1];

  // Falling edge of the bit clock; sin_d_q still holds the data seen while SCLK was high.
  assign bit_edge = ~sclk_s & sclk_d_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      sclk_sync_q <= '0;
      sin_sync_q  <= '0;
      sclk_d_q    <= 1'b0;
      sin_d_q     <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK_IN};
      sin_sync_q  <= {sin_sync_q[SYNC_STAGES-2:0], SIN};
      sclk_d_q    <= sclk_s;
      sin_d_q     <= sin_s;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      to_cnt_q   <= '0;
      shreg_q    <= '0;
      dout_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      to_cnt_q   <= to_cnt_d;
      shreg_q    <= shreg_d;
      dout_q     <= dout_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = to_cnt_q;
    shreg_d    = shreg_q;
    dout_d     = dout_q;
    rx_valid_d = rx_valid_q;
    rx_err_d   = rx_err_q;
    overrun_d  = overrun_q;

    if (RX_ACK) begin
      rx_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (RX_START) begin
          state_d   = StRecv;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
          rx_err_d  = 1'b0;
        end
      end
      StRecv: begin
        if (bit_edge) begin
          shreg_d   = {sin_d_q, shreg_q[WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BitCntW'(1);
          to_cnt_d  = '0;
          if (bit_cnt_d == BitLast) begin
            state_d = StDone;
          end
        end else begin
          to_cnt_d = to_cnt_q + ToCntW'(1);
          if (to_cnt_d == ToLast) begin
            rx_err_d = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StDone: begin
        // Completion beats a same-cycle acknowledge.
        dout_d     = shreg_q;
        rx_valid_d = 1'b1;
        if (rx_valid_q) begin
          overrun_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign DOUT     = dout_q;
  assign RX_VALID = rx_valid_q;
  assign RX_DONE  = (state_q == StDone);
  assign RX_BUSY  = (state_q == StRecv);
  assign RX_ERR   = rx_err_q;
  assign OVERRUN  = overrun_q;

endmodule

// File: doc/serial_rx_deserializer.md
Name: serial_rx_deserializer

Overview:
- Receive end of the 32-bit LSB-first parallel-load shift transmitter link.
- Samples the serial data line SIN and the transmitter bit clock SCLK_IN, both oversampled in the system clock domain, and rebuilds the parallel word.
- Presents the word on DOUT with a valid/ack handshake toward the consuming logic.
- Reports frame completion, bit-clock timeout, and overrun.

Parameters:
- WIDTH, 32: bits per frame and DOUT width.
- SYNC_STAGES, 2: synchronizer flops on SCLK_IN and SIN, minimum 2.
- TIMEOUT, 64: maximum CLK cycles allowed between accepted bit edges while receiving.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RESET_N  input  1  synchronous, active-low reset.
- SCLK_IN  input  1  transmitter bit clock, asynchronous to CLK.
- SIN  input  1  serial data, asynchronous to CLK; valid only while SCLK_IN is high.
- RX_START  input  1  one-cycle pulse; arms reception of one frame.
- RX_ACK  input  1  consumer has taken DOUT; clears RX_VALID.
- DOUT  output  WIDTH  last completed word.
- RX_VALID  output  1  DOUT holds an unacknowledged word.
- RX_DONE  output  1  one-cycle pulse on frame completion.
- RX_BUSY  output  1  high while in RECV.
- RX_ERR  output  1  sticky timeout flag.
- OVERRUN  output  1  sticky; a word completed while RX_VALID was still 1.

Behaviour:
- Reset (RESET_N low at a CLK edge):
  - Outputs: DOUT=0, RX_VALID=0, RX_DONE=0, RX_BUSY=0, RX_ERR=0, OVERRUN=0.
  - Internal: state=IDLE, bit counter=0, timeout counter=0, synchronizers=0.
  - Reset overrides every other input, including mid-frame.
- Synchronization: SCLK_IN and SIN each pass through SYNC_STAGES flops. A one-cycle-delayed copy of each synchronized signal is also kept (sclk_d, sin_d).
- Bit edge: synchronized SCLK is 0 while sclk_d is 1 (falling edge).
  - Sampled bit = sin_d, the last value seen while SCLK was high.
  - Edges in IDLE are ignored.
- IDLE:
  - RX_START=1 → RECV. Clear bit counter, timeout counter, and RX_ERR.
  - An edge in the same cycle as RX_START is not captured.
- RECV:
  - RX_BUSY=1.
  - On each edge: shift register <= {bit, shreg[WIDTH-1:1]} (first bit lands in DOUT[0]), bit counter +1, timeout counter cleared.
  - Otherwise the timeout counter increments.
  - Timeout counter reaches TIMEOUT-1 with no edge → RX_ERR=1, go IDLE. DOUT and RX_VALID are unchanged.
  - Edge that makes the count equal WIDTH → DONE.
  - RX_START while in RECV is ignored.
- DONE (one cycle):
  - DOUT <= assembled word, RX_DONE=1, RX_VALID<=1.
  - If RX_VALID was already 1, OVERRUN<=1 and DOUT is still overwritten.
  - Next state IDLE.
  - Latency: RX_DONE is high in the cycle after the CLK edge that detects the final falling edge.
- RX_VALID:
  - Cleared by RX_ACK=1 in any cycle except the DONE cycle; in the DONE cycle the completion wins and RX_VALID stays 1.
  - RX_ACK with RX_VALID=0 has no effect.
- Sticky flags:
  - OVERRUN clears only on reset.
  - RX_ERR clears on reset or on an accepted RX_START.
- Counters:
  - Bit counter width: clog2(WIDTH+1).
  - Timeout counter width: clog2(TIMEOUT+1).
  - No wrap-around is possible in either, by construction.
- Bit rate: the transmitter bit clock high and low phases must each last at least SYNC_STAGES+1 CLK cycles. Faster clocks are out of spec and may drop bits.

Test Plan:
1. Normal frame:
   - Stimulus: reset, RX_START, then 32 bits of 32'h12345678 LSB first. SCLK high 5 CLK, low 15 CLK; SIN driven = bit & SCLK.
   - Required: RX_DONE pulses once; DOUT=32'h12345678; RX_VALID=1; RX_BUSY drops in the DONE cycle; RX_ERR=0.
2. Handshake collision:
   - Stimulus: with RX_VALID=1, receive 32'hA5A5_0F0F; assert RX_ACK exactly in the DONE cycle.
   - Required: RX_VALID stays 1; DOUT=32'hA5A50F0F; OVERRUN=1.
   - Follow-up: RX_ACK on the next cycle → RX_VALID=0.
3. Timeout:
   - Stimulus: RX_START, 10 bit edges, then SCLK held low.
   - Required: RX_ERR=1 exactly TIMEOUT-1 cycles after the 10th edge; state IDLE; RX_BUSY=0; DOUT keeps its prior value; no RX_DONE.
   - Follow-up: a subsequent RX_START clears RX_ERR.
4. Reset mid-frame:
   - Stimulus: RESET_N low for 1 CLK after 16 bits.
   - Required: all outputs 0 next cycle.
   - Follow-up: a fresh full frame of 32'hFFFF_0001 is received correctly.
5. Idle and ignored events:
   - Stimulus: 40 SCLK edges with no RX_START; then RX_START re-pulsed during RECV.
   - Required: no RX_DONE, no DOUT change while idle; the re-pulse does not restart the bit count.
6. Back-to-back frames:
   - Stimulus: RX_START issued in the cycle after RX_DONE; frames 32'h00000001 then 32'h80000000, each acknowledged after its RX_DONE.
   - Required: both words captured in order; OVERRUN=0.
